// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
// Shared definitions for the RV32I pipeline control unit: opcode constants,
// the ALU operation and forward-select encodings, the control bundle that
// travels EX -> MEM -> WB, and the forwarding priority helper.
package pipeline_ctrl_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_XOR = 4'b0001,
    ALU_SLL = 4'b0010,
    ALU_ADD = 4'b0011,
    ALU_SUB = 4'b0100,
    ALU_MUL = 4'b0101,
    ALU_SRA = 4'b0110
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    FWD_IDEX = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic      reg_write;
    logic      mem_to_reg;
    logic      mem_read;
    logic      mem_write;
    logic      alu_src;
    alu_ctrl_e alu_ctrl;
    logic      branch;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ctrl_bundle_t;

  // The younger result (MEM) wins over the older one (WB); x0 never forwards.
  function automatic fwd_sel_e fwd_select(input logic [4:0] rs,
                                          input ctrl_bundle_t mem_b,
                                          input ctrl_bundle_t wb_b);
    fwd_sel_e sel;
    sel = FWD_IDEX;
    if (mem_b.reg_write && (mem_b.rd != 5'd0) && (mem_b.rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_b.reg_write && (wb_b.rd != 5'd0) && (wb_b.rd == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_decoder.sv
// ctrl_decoder
// Purely combinational instruction decoder for the ID stage.
// Ports:
//   instr_i  32-bit instruction held in IF/ID
//   ctrl_o   decoded control bundle (all zero for unsupported encodings)
module ctrl_decoder
  import pipeline_ctrl_pkg::*;
(
  input  logic [31:0]  instr_i,
  output ctrl_bundle_t ctrl_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign funct7 = instr_i[31:25];

  logic         valid;
  ctrl_bundle_t bundle;

  // rs2 is only filled in for formats that actually read it (R, S, B), so a
  // zero rs2 can never match a nonzero load destination in the stall check
  // and never requests forwarding on an immediate operand.
  always_comb begin
    valid  = 1'b1;
    bundle = '0;
    case (opcode)
      OPC_RTYPE: begin
        bundle.reg_write = 1'b1;
        bundle.rd        = rd;
        bundle.rs1       = rs1;
        bundle.rs2       = rs2;
        case ({funct7, funct3})
          {7'b0000000, 3'b111}: bundle.alu_ctrl = ALU_AND;
          {7'b0000000, 3'b100}: bundle.alu_ctrl = ALU_XOR;
          {7'b0000000, 3'b001}: bundle.alu_ctrl = ALU_SLL;
          {7'b0000000, 3'b000}: bundle.alu_ctrl = ALU_ADD;
          {7'b0100000, 3'b000}: bundle.alu_ctrl = ALU_SUB;
          {7'b0000001, 3'b000}: bundle.alu_ctrl = ALU_MUL;
          default:              valid = 1'b0;
        endcase
      end
      OPC_IMM: begin
        bundle.reg_write = 1'b1;
        bundle.alu_src   = 1'b1;
        bundle.rd        = rd;
        bundle.rs1       = rs1;
        if (funct3 == 3'b000) begin
          bundle.alu_ctrl = ALU_ADD;
        end else if ((funct3 == 3'b101) && (funct7 == 7'b0100000)) begin
          bundle.alu_ctrl = ALU_SRA;
        end else begin
          valid = 1'b0;
        end
      end
      OPC_LOAD: begin
        bundle.reg_write  = 1'b1;
        bundle.mem_to_reg = 1'b1;
        bundle.mem_read   = 1'b1;
        bundle.alu_src    = 1'b1;
        bundle.alu_ctrl   = ALU_ADD;
        bundle.rd         = rd;
        bundle.rs1        = rs1;
        valid             = (funct3 == 3'b010);
      end
      OPC_STORE: begin
        bundle.mem_write = 1'b1;
        bundle.alu_src   = 1'b1;
        bundle.alu_ctrl  = ALU_ADD;
        bundle.rs1       = rs1;
        bundle.rs2       = rs2;
        valid            = (funct3 == 3'b010);
      end
      OPC_BRANCH: begin
        bundle.branch   = 1'b1;
        bundle.alu_ctrl = ALU_SUB;
        bundle.rs1      = rs1;
        bundle.rs2      = rs2;
        valid           = (funct3 == 3'b000);
      end
      default: valid = 1'b0;
    endcase
    // Writes to x0 are architecturally discarded, so drop the write enable
    // here; this also keeps x0 out of the forwarding paths.
    if (bundle.rd == 5'd0) begin
      bundle.reg_write = 1'b0;
    end
    ctrl_o = valid ? bundle : '0;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Control and hazard unit for the 5-stage RV32I pipeline. Decodes the
// instruction in ID, carries the control bundle through EX/MEM/WB stage
// registers, detects load-use stalls, resolves taken branches in MEM and
// generates EX operand forwarding selects. Saturating debug counters track
// stalls and flushes.
// Ports:
//   clk_i, rst_n_i                     clock, synchronous active-low reset
//   instr_id_i                         instruction in ID
//   zero_mem_i                         ALU zero flag held in EX/MEM
//   pc_write_o, ifid_write_o           PC / IF/ID load enables
//   ifid/idex/exmem_flush_o            pipeline register bubble requests
//   pc_src_o                           0 = PC+4, 1 = branch target
//   alu_src_o, alu_ctrl_o              EX controls
//   fwd_a_o, fwd_b_o                   EX operand forward selects
//   mem_read_o, mem_write_o            MEM controls
//   reg_write_o, mem_to_reg_o, wb_rd_o WB controls
//   stall_cnt_o, flush_cnt_o           saturating event counters
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [31:0]      instr_id_i,
  input  logic             zero_mem_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             exmem_flush_o,
  output logic             pc_src_o,
  output logic             alu_src_o,
  output logic [3:0]       alu_ctrl_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             reg_write_o,
  output logic             mem_to_reg_o,
  output logic [4:0]       wb_rd_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  ctrl_bundle_t id_ctrl;
  ctrl_bundle_t ex_q, ex_d;
  ctrl_bundle_t mem_q, mem_d;
  ctrl_bundle_t wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic     load_use;
  logic     branch_taken;
  fwd_sel_e fwd_a;
  fwd_sel_e fwd_b;

  ctrl_decoder u_decoder (
    .instr_i (instr_id_i),
    .ctrl_o  (id_ctrl)
  );

  // Non-R/S/B instructions decode with rs2 = 0, so the rd != 0 guard already
  // restricts the rs2 comparison to formats that read rs2.
  assign load_use = ex_q.mem_read && (ex_q.rd != 5'd0) &&
                    ((ex_q.rd == id_ctrl.rs1) || (ex_q.rd == id_ctrl.rs2));

  assign branch_taken = mem_q.branch && zero_mem_i;

  assign fwd_a = fwd_select(ex_q.rs1, mem_q, wb_q);
  assign fwd_b = fwd_select(ex_q.rs2, mem_q, wb_q);

  // A taken branch discards whatever is stalled behind it, so it overrides
  // the stall and lets the PC load the branch target.
  assign pc_write_o    = rst_n_i && (!load_use || branch_taken);
  assign ifid_write_o  = rst_n_i && (!load_use || branch_taken);
  assign ifid_flush_o  = rst_n_i && branch_taken;
  assign idex_flush_o  = rst_n_i && (branch_taken || load_use);
  assign exmem_flush_o = rst_n_i && branch_taken;
  assign pc_src_o      = rst_n_i && branch_taken;
  assign fwd_a_o       = rst_n_i ? fwd_a : FWD_IDEX;
  assign fwd_b_o       = rst_n_i ? fwd_b : FWD_IDEX;

  assign alu_src_o    = ex_q.alu_src;
  assign alu_ctrl_o   = ex_q.alu_ctrl;
  assign mem_read_o   = mem_q.mem_read;
  assign mem_write_o  = mem_q.mem_write;
  assign reg_write_o  = wb_q.reg_write;
  assign mem_to_reg_o = wb_q.mem_to_reg;
  assign wb_rd_o      = wb_q.rd;
  assign stall_cnt_o  = stall_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;

  // Next-state for the stage bundles and the saturating counters. A stall
  // only inserts a bubble into EX; the load itself keeps moving to MEM.
  always_comb begin
    ex_d        = (load_use || branch_taken) ? '0 : id_ctrl;
    mem_d       = branch_taken ? '0 : ex_q;
    wb_d        = mem_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (load_use && !branch_taken && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (branch_taken && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // The WB register keeps the whole bundle for debug visibility even though
  // only the write-back fields drive outputs.
  logic wb_fields_unused;
  assign wb_fields_unused = ^{wb_q.mem_read, wb_q.mem_write, wb_q.alu_src,
                              wb_q.alu_ctrl, wb_q.branch, wb_q.rs1, wb_q.rs2};

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
// Self-checking bench for pipeline_ctrl, built with CNT_W = 4 so counter
// saturation is reachable quickly.
module tb_pipeline_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n_i;
  logic [31:0]      instr_id_i;
  logic             zero_mem_i;
  logic             pc_write_o, ifid_write_o;
  logic             ifid_flush_o, idex_flush_o, exmem_flush_o;
  logic             pc_src_o, alu_src_o;
  logic [3:0]       alu_ctrl_o;
  logic [1:0]       fwd_a_o, fwd_b_o;
  logic             mem_read_o, mem_write_o, reg_write_o, mem_to_reg_o;
  logic [4:0]       wb_rd_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  int checks   = 0;
  int failures = 0;
  int expStall = 0;
  int expFlush = 0;

  typedef struct packed {
    logic [3:0] alu;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] rd;
  } exp_t;

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n_i),
    .instr_id_i    (instr_id_i),
    .zero_mem_i    (zero_mem_i),
    .pc_write_o    (pc_write_o),
    .ifid_write_o  (ifid_write_o),
    .ifid_flush_o  (ifid_flush_o),
    .idex_flush_o  (idex_flush_o),
    .exmem_flush_o (exmem_flush_o),
    .pc_src_o      (pc_src_o),
    .alu_src_o     (alu_src_o),
    .alu_ctrl_o    (alu_ctrl_o),
    .fwd_a_o       (fwd_a_o),
    .fwd_b_o       (fwd_b_o),
    .mem_read_o    (mem_read_o),
    .mem_write_o   (mem_write_o),
    .reg_write_o   (reg_write_o),
    .mem_to_reg_o  (mem_to_reg_o),
    .wb_rd_o       (wb_rd_o),
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction encoders
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0000000, rs2, rs1, 3'b000, 5'b01000, 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_lw(input logic [4:0] rd);
    return enc_i(12'd0, 5'd0, 3'b010, rd, 7'b0000011);
  endfunction

  // Advance to just after the next rising edge.
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Feed bubbles until the pipeline is empty.
  task automatic idle_cycles(input int n);
    instr_id_i = 32'h0;
    zero_mem_i = 1'b0;
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic test_reset;
    rst_n_i    = 1'b0;
    zero_mem_i = 1'b1;
    instr_id_i = enc_b(5'd1, 5'd2);
    for (int i = 0; i < 3; i++) next_cycle();
    @(negedge clk);
    checks++; if (pc_write_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_pc_write got=%0b exp=0", pc_write_o); end
    checks++; if (ifid_write_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_ifid_write got=%0b exp=0", ifid_write_o); end
    checks++; if ({ifid_flush_o, idex_flush_o, exmem_flush_o, pc_src_o} !== 4'b0) begin failures++; $display("[TB] FAIL rst_flush_pcsrc got=%b exp=0000", {ifid_flush_o, idex_flush_o, exmem_flush_o, pc_src_o}); end
    checks++; if ({fwd_a_o, fwd_b_o} !== 4'b0) begin failures++; $display("[TB] FAIL rst_fwd got=%b exp=0000", {fwd_a_o, fwd_b_o}); end
    checks++; if ({alu_src_o, alu_ctrl_o, mem_read_o, mem_write_o} !== 7'b0) begin failures++; $display("[TB] FAIL rst_ex_mem got=%b exp=0", {alu_src_o, alu_ctrl_o, mem_read_o, mem_write_o}); end
    checks++; if ({reg_write_o, mem_to_reg_o, wb_rd_o} !== 7'b0) begin failures++; $display("[TB] FAIL rst_wb got=%b exp=0", {reg_write_o, mem_to_reg_o, wb_rd_o}); end
    checks++; if ({stall_cnt_o, flush_cnt_o} !== '0) begin failures++; $display("[TB] FAIL rst_counters got=%0d/%0d exp=0/0", stall_cnt_o, flush_cnt_o); end
    // Release with addi x0,x0,0 held in ID
    @(posedge clk); #1;
    rst_n_i    = 1'b1;
    zero_mem_i = 1'b0;
    instr_id_i = 32'h0000_0013;
    next_cycle();
    @(negedge clk);
    checks++; if (pc_write_o !== 1'b1) begin failures++; $display("[TB] FAIL release_pc_write got=%0b exp=1", pc_write_o); end
    checks++; if ({alu_ctrl_o, alu_src_o} !== {4'b0011, 1'b1}) begin failures++; $display("[TB] FAIL release_addi_ex got=%b exp=00111", {alu_ctrl_o, alu_src_o}); end
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++; if ({reg_write_o, wb_rd_o} !== 6'b0) begin failures++; $display("[TB] FAIL release_x0_write got=%b exp=000000", {reg_write_o, wb_rd_o}); end
    next_cycle();
  endtask

  // Scoreboard: expected controls are queued when an instruction is driven
  // into ID and popped as it shows up in EX, then MEM, then WB.
  task automatic test_decode;
    logic [31:0] instrs[13];
    exp_t        exps[13];
    exp_t        exQ[$];
    exp_t        memQ[$];
    exp_t        wbQ[$];
    exp_t        e;
    instrs[0]  = enc_r(7'h00, 3'b111, 5'd1, 5'd2, 5'd3);        exps[0]  = '{4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1};
    instrs[1]  = enc_r(7'h00, 3'b100, 5'd2, 5'd3, 5'd4);        exps[1]  = '{4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2};
    instrs[2]  = enc_r(7'h00, 3'b001, 5'd3, 5'd4, 5'd5);        exps[2]  = '{4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3};
    instrs[3]  = enc_r(7'h00, 3'b000, 5'd4, 5'd5, 5'd6);        exps[3]  = '{4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4};
    instrs[4]  = enc_r(7'h20, 3'b000, 5'd8, 5'd9, 5'd10);       exps[4]  = '{4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8};
    instrs[5]  = enc_r(7'h01, 3'b000, 5'd11, 5'd12, 5'd13);     exps[5]  = '{4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd11};
    instrs[6]  = enc_i(12'd5, 5'd15, 3'b000, 5'd14, 7'b0010011); exps[6]  = '{4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd14};
    instrs[7]  = enc_i(12'h403, 5'd17, 3'b101, 5'd16, 7'b0010011); exps[7] = '{4'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd16};
    instrs[8]  = enc_i(12'd4, 5'd21, 3'b010, 5'd20, 7'b0000011); exps[8]  = '{4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd20};
    instrs[9]  = enc_s(5'd22, 5'd23, 12'd8);                    exps[9]  = '{4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0};
    instrs[10] = enc_b(5'd24, 5'd25);                           exps[10] = '{4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    instrs[11] = 32'h1234_5037;                                 exps[11] = '0;
    instrs[12] = 32'hFFFF_FFFF;                                 exps[12] = '0;
    zero_mem_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      instr_id_i = (i < 13) ? instrs[i] : 32'h0;
      @(negedge clk);
      if (wbQ.size() > 0) begin
        e = wbQ.pop_front();
        checks++;
        if ({reg_write_o, mem_to_reg_o, wb_rd_o} !== {e.reg_write, e.mem_to_reg, e.rd}) begin
          failures++; $display("[TB] FAIL decode_wb[%0d] got=%b exp=%b", i - 3, {reg_write_o, mem_to_reg_o, wb_rd_o}, {e.reg_write, e.mem_to_reg, e.rd});
        end
      end
      if (memQ.size() > 0) begin
        e = memQ.pop_front();
        checks++;
        if ({mem_read_o, mem_write_o} !== {e.mem_read, e.mem_write}) begin
          failures++; $display("[TB] FAIL decode_mem[%0d] got=%b exp=%b", i - 2, {mem_read_o, mem_write_o}, {e.mem_read, e.mem_write});
        end
        wbQ.push_back(e);
      end
      if (exQ.size() > 0) begin
        e = exQ.pop_front();
        checks++;
        if ({alu_ctrl_o, alu_src_o} !== {e.alu, e.alu_src}) begin
          failures++; $display("[TB] FAIL decode_ex[%0d] got=%b exp=%b", i - 1, {alu_ctrl_o, alu_src_o}, {e.alu, e.alu_src});
        end
        memQ.push_back(e);
      end
      if (i < 13) exQ.push_back(exps[i]);
      next_cycle();
    end
    idle_cycles(3);
  endtask

  task automatic test_load_use;
    instr_id_i = enc_lw(5'd5);
    next_cycle();
    instr_id_i = enc_r(7'h00, 3'b000, 5'd6, 5'd5, 5'd1);
    @(negedge clk);
    checks++; if ({pc_write_o, ifid_write_o} !== 2'b00) begin failures++; $display("[TB] FAIL lu_hold got=%b exp=00", {pc_write_o, ifid_write_o}); end
    checks++; if ({ifid_flush_o, idex_flush_o, exmem_flush_o} !== 3'b010) begin failures++; $display("[TB] FAIL lu_flush got=%b exp=010", {ifid_flush_o, idex_flush_o, exmem_flush_o}); end
    next_cycle();
    expStall++;
    @(negedge clk);
    checks++; if ({alu_ctrl_o, alu_src_o} !== 5'b0) begin failures++; $display("[TB] FAIL lu_bubble got=%b exp=00000", {alu_ctrl_o, alu_src_o}); end
    checks++; if (mem_read_o !== 1'b1) begin failures++; $display("[TB] FAIL lu_load_in_mem got=%0b exp=1", mem_read_o); end
    checks++; if (pc_write_o !== 1'b1) begin failures++; $display("[TB] FAIL lu_one_cycle got=%0b exp=1", pc_write_o); end
    checks++; if (stall_cnt_o !== CNT_W'(expStall)) begin failures++; $display("[TB] FAIL lu_stall_cnt got=%0d exp=%0d", stall_cnt_o, expStall); end
    next_cycle();
    instr_id_i = 32'h0;
    @(negedge clk);
    checks++; if ({fwd_a_o, fwd_b_o} !== 4'b0100) begin failures++; $display("[TB] FAIL lu_fwd_wb got=%b exp=0100", {fwd_a_o, fwd_b_o}); end
    checks++; if ({reg_write_o, mem_to_reg_o, wb_rd_o} !== {2'b11, 5'd5}) begin failures++; $display("[TB] FAIL lu_wb_load got=%b exp=1100101", {reg_write_o, mem_to_reg_o, wb_rd_o}); end
    idle_cycles(3);
  endtask

  task automatic test_forwarding;
    // EX/MEM forwarding on both operands
    instr_id_i = enc_r(7'h00, 3'b000, 5'd1, 5'd2, 5'd3);
    next_cycle();
    instr_id_i = enc_r(7'h20, 3'b000, 5'd4, 5'd1, 5'd1);
    next_cycle();
    instr_id_i = 32'h0;
    @(negedge clk);
    checks++; if ({fwd_a_o, fwd_b_o} !== 4'b1010) begin failures++; $display("[TB] FAIL fwd_mem got=%b exp=1010", {fwd_a_o, fwd_b_o}); end
    checks++; if (alu_ctrl_o !== 4'b0100) begin failures++; $display("[TB] FAIL fwd_sub_alu got=%b exp=0100", alu_ctrl_o); end
    idle_cycles(3);
    // rd = x0 never forwards
    instr_id_i = enc_r(7'h00, 3'b000, 5'd0, 5'd2, 5'd3);
    next_cycle();
    instr_id_i = enc_r(7'h20, 3'b000, 5'd4, 5'd0, 5'd0);
    next_cycle();
    instr_id_i = 32'h0;
    @(negedge clk);
    checks++; if ({fwd_a_o, fwd_b_o} !== 4'b0000) begin failures++; $display("[TB] FAIL fwd_x0 got=%b exp=0000", {fwd_a_o, fwd_b_o}); end
    idle_cycles(3);
    // WB-only forwarding on operand B
    instr_id_i = enc_r(7'h00, 3'b000, 5'd1, 5'd2, 5'd3);
    next_cycle();
    instr_id_i = 32'h0;
    next_cycle();
    instr_id_i = enc_r(7'h20, 3'b000, 5'd4, 5'd7, 5'd1);
    next_cycle();
    instr_id_i = 32'h0;
    @(negedge clk);
    checks++; if ({fwd_a_o, fwd_b_o} !== 4'b0001) begin failures++; $display("[TB] FAIL fwd_wb_b got=%b exp=0001", {fwd_a_o, fwd_b_o}); end
    idle_cycles(3);
    // MEM wins over WB when both hold the same rd
    instr_id_i = enc_r(7'h00, 3'b000, 5'd1, 5'd2, 5'd3);
    next_cycle();
    instr_id_i = enc_r(7'h00, 3'b000, 5'd1, 5'd4, 5'd5);
    next_cycle();
    instr_id_i = enc_r(7'h20, 3'b000, 5'd4, 5'd1, 5'd2);
    next_cycle();
    instr_id_i = 32'h0;
    @(negedge clk);
    checks++; if ({fwd_a_o, fwd_b_o} !== 4'b1000) begin failures++; $display("[TB] FAIL fwd_priority got=%b exp=1000", {fwd_a_o, fwd_b_o}); end
    idle_cycles(3);
  endtask

  task automatic test_branch;
    // Taken
    instr_id_i = enc_b(5'd1, 5'd2);
    next_cycle();
    instr_id_i = enc_r(7'h00, 3'b000, 5'd7, 5'd8, 5'd9);
    next_cycle();
    instr_id_i = enc_r(7'h00, 3'b000, 5'd10, 5'd11, 5'd12);
    zero_mem_i = 1'b1;
    @(negedge clk);
    checks++; if ({pc_src_o, pc_write_o} !== 2'b11) begin failures++; $display("[TB] FAIL br_pc got=%b exp=11", {pc_src_o, pc_write_o}); end
    checks++; if ({ifid_flush_o, idex_flush_o, exmem_flush_o} !== 3'b111) begin failures++; $display("[TB] FAIL br_flush got=%b exp=111", {ifid_flush_o, idex_flush_o, exmem_flush_o}); end
    next_cycle();
    expFlush++;
    zero_mem_i = 1'b0;
    instr_id_i = 32'h0;
    @(negedge clk);
    checks++; if (flush_cnt_o !== CNT_W'(expFlush)) begin failures++; $display("[TB] FAIL br_flush_cnt got=%0d exp=%0d", flush_cnt_o, expFlush); end
    checks++; if ({alu_ctrl_o, alu_src_o, pc_src_o} !== 6'b0) begin failures++; $display("[TB] FAIL br_bubble1 got=%b exp=0", {alu_ctrl_o, alu_src_o, pc_src_o}); end
    next_cycle();
    @(negedge clk);
    checks++; if ({reg_write_o, wb_rd_o, mem_read_o, mem_write_o} !== 8'b0) begin failures++; $display("[TB] FAIL br_bubble2 got=%b exp=0", {reg_write_o, wb_rd_o, mem_read_o, mem_write_o}); end
    idle_cycles(3);
    // Not taken
    instr_id_i = enc_b(5'd1, 5'd2);
    next_cycle();
    instr_id_i = enc_r(7'h00, 3'b000, 5'd7, 5'd8, 5'd9);
    next_cycle();
    instr_id_i = enc_r(7'h00, 3'b000, 5'd10, 5'd11, 5'd12);
    zero_mem_i = 1'b0;
    @(negedge clk);
    checks++; if ({pc_src_o, ifid_flush_o, idex_flush_o, exmem_flush_o} !== 4'b0) begin failures++; $display("[TB] FAIL br_nt_flush got=%b exp=0000", {pc_src_o, ifid_flush_o, idex_flush_o, exmem_flush_o}); end
    next_cycle();
    instr_id_i = 32'h0;
    @(negedge clk);
    checks++; if (alu_ctrl_o !== 4'b0011) begin failures++; $display("[TB] FAIL br_nt_ex got=%b exp=0011", alu_ctrl_o); end
    checks++; if (flush_cnt_o !== CNT_W'(expFlush)) begin failures++; $display("[TB] FAIL br_nt_cnt got=%0d exp=%0d", flush_cnt_o, expFlush); end
    idle_cycles(3);
  endtask

  task automatic test_simultaneous;
    instr_id_i = enc_b(5'd1, 5'd2);
    next_cycle();
    instr_id_i = enc_lw(5'd5);
    next_cycle();
    instr_id_i = enc_r(7'h00, 3'b000, 5'd6, 5'd5, 5'd1);
    zero_mem_i = 1'b1;
    @(negedge clk);
    checks++; if ({pc_write_o, ifid_write_o, pc_src_o} !== 3'b111) begin failures++; $display("[TB] FAIL sim_pc got=%b exp=111", {pc_write_o, ifid_write_o, pc_src_o}); end
    checks++; if ({ifid_flush_o, idex_flush_o, exmem_flush_o} !== 3'b111) begin failures++; $display("[TB] FAIL sim_flush got=%b exp=111", {ifid_flush_o, idex_flush_o, exmem_flush_o}); end
    next_cycle();
    expFlush++;
    zero_mem_i = 1'b0;
    instr_id_i = 32'h0;
    @(negedge clk);
    checks++; if (stall_cnt_o !== CNT_W'(expStall)) begin failures++; $display("[TB] FAIL sim_stall_cnt got=%0d exp=%0d", stall_cnt_o, expStall); end
    checks++; if (flush_cnt_o !== CNT_W'(expFlush)) begin failures++; $display("[TB] FAIL sim_flush_cnt got=%0d exp=%0d", flush_cnt_o, expFlush); end
    checks++; if (mem_read_o !== 1'b0) begin failures++; $display("[TB] FAIL sim_load_squashed got=%0b exp=0", mem_read_o); end
    idle_cycles(3);
  endtask

  task automatic test_saturation;
    for (int k = 0; k < 20; k++) begin
      instr_id_i = enc_lw(5'd5);
      next_cycle();
      instr_id_i = enc_r(7'h00, 3'b000, 5'd6, 5'd5, 5'd1);
      next_cycle();
      if (expStall < CNT_MAX) expStall++;
      @(negedge clk);
      checks++; if (stall_cnt_o !== CNT_W'(expStall)) begin failures++; $display("[TB] FAIL sat_step[%0d] got=%0d exp=%0d", k, stall_cnt_o, expStall); end
      next_cycle();
    end
    checks++; if (stall_cnt_o !== 4'd15) begin failures++; $display("[TB] FAIL sat_final got=%0d exp=15", stall_cnt_o); end
  endtask

  task automatic test_reset_midop;
    // Reset during a load-use stall
    instr_id_i = enc_lw(5'd5);
    next_cycle();
    instr_id_i = enc_r(7'h00, 3'b000, 5'd6, 5'd5, 5'd1);
    rst_n_i    = 1'b0;
    @(negedge clk);
    checks++; if ({pc_write_o, ifid_write_o, idex_flush_o} !== 3'b000) begin failures++; $display("[TB] FAIL rstmid_comb got=%b exp=000", {pc_write_o, ifid_write_o, idex_flush_o}); end
    next_cycle();
    @(negedge clk);
    checks++; if ({stall_cnt_o, flush_cnt_o} !== '0) begin failures++; $display("[TB] FAIL rstmid_counters got=%0d/%0d exp=0/0", stall_cnt_o, flush_cnt_o); end
    checks++; if ({mem_read_o, alu_ctrl_o} !== 5'b0) begin failures++; $display("[TB] FAIL rstmid_stages got=%b exp=00000", {mem_read_o, alu_ctrl_o}); end
    rst_n_i = 1'b1;
    expStall = 0;
    expFlush = 0;
    idle_cycles(3);
    // Reset while a taken branch sits in MEM
    instr_id_i = enc_b(5'd1, 5'd2);
    next_cycle();
    instr_id_i = 32'h0;
    next_cycle();
    zero_mem_i = 1'b1;
    rst_n_i    = 1'b0;
    @(negedge clk);
    checks++; if ({pc_src_o, ifid_flush_o, exmem_flush_o} !== 3'b000) begin failures++; $display("[TB] FAIL rstbr_comb got=%b exp=000", {pc_src_o, ifid_flush_o, exmem_flush_o}); end
    next_cycle();
    rst_n_i    = 1'b1;
    @(negedge clk);
    checks++; if ({flush_cnt_o, pc_src_o} !== 5'b0) begin failures++; $display("[TB] FAIL rstbr_after got=%b exp=00000", {flush_cnt_o, pc_src_o}); end
    idle_cycles(2);
  endtask

  initial begin
    rst_n_i    = 1'b0;
    instr_id_i = 32'h0;
    zero_mem_i = 1'b0;
    test_reset();
    test_decode();
    test_load_use();
    test_forwarding();
    test_branch();
    test_simultaneous();
    test_saturation();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
